// File: rtl/cl_dmem_ctrl_pkg.sv
// Shared types for the data-memory controller.
// States and the latched pipeline request.
package cl_dmem_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        RESP    = 3'd4
    } dmem_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        store;
        logic        is_byte;
    } dmem_req_s;

endpackage

// File: rtl/cl_dmem_ctrl_byte_lane.sv
// Little-endian byte lane helper: zero-extended extract
// and single-byte merge into a 32-bit word.
module cl_byte_lane (
    input  logic [31:0] word_i,
    input  logic [1:0]  lane_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] extract_o,
    output logic [31:0] merge_o
);

    logic [4:0] sh;

    always_comb begin
        sh = {lane_i, 3'b000};
        extract_o = {24'b0, word_i[sh +: 8]};
        merge_o = word_i;
        merge_o[sh +: 8] = byte_i;
    end

endmodule

// File: rtl/cl_dmem_ctrl.sv
// Memory-stage responder: one request at a time, byte loads
// by extraction and byte stores by read-modify-write.
module cl_dmem_ctrl
    import cl_dmem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_v_i,
    output logic              req_ready_o,
    input  logic [31:0]       req_addr_i,
    input  logic [31:0]       req_data_i,
    input  logic              req_store_i,
    input  logic              req_byte_i,
    output logic              resp_v_o,
    output logic [31:0]       resp_data_o,
    output logic              busy_o,
    output logic              mem_v_o,
    input  logic              mem_ready_i,
    output logic              mem_w_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_data_o,
    input  logic              mem_rv_i,
    input  logic [31:0]       mem_rdata_i
);

    if (DATA_W != 32) begin : g_bad_width
        $error("cl_dmem_ctrl: DATA_W must be 32");
    end

    dmem_state_e state_q, state_d;
    dmem_req_s   req_q, req_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] lane_ext;
    logic [31:0] lane_mrg;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^req_q.addr[31:ADDR_W+2];

    cl_byte_lane u_lane (
        .word_i    (mem_rdata_i),
        .lane_i    (req_q.addr[1:0]),
        .byte_i    (req_q.data[7:0]),
        .extract_o (lane_ext),
        .merge_o   (lane_mrg)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        req_ready_o = 1'b0;
        resp_v_o    = 1'b0;
        mem_v_o     = 1'b0;
        mem_w_o     = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_v_i) begin
                    req_d.addr    = req_addr_i;
                    req_d.data    = req_data_i;
                    req_d.store   = req_store_i;
                    req_d.is_byte = req_byte_i;
                    // only word stores skip the read phase
                    state_d = (req_store_i && !req_byte_i)
                            ? WR_REQ : RD_REQ;
                end
            end
            RD_REQ: begin
                mem_v_o = 1'b1;
                if (mem_ready_i) state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (mem_rv_i) begin
                    if (!req_q.store) begin
                        rdata_d = req_q.is_byte ? lane_ext : mem_rdata_i;
                        state_d = RESP;
                    end else begin
                        wdata_d = lane_mrg;
                        state_d = WR_REQ;
                    end
                end
            end
            WR_REQ: begin
                mem_v_o = 1'b1;
                mem_w_o = 1'b1;
                if (mem_ready_i) begin
                    rdata_d = '0;
                    state_d = RESP;
                end
            end
            RESP: begin
                resp_v_o = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o      = (state_q != IDLE);
    assign resp_data_o = rdata_q;
    assign mem_addr_o  = req_q.addr[ADDR_W+1:2];
    assign mem_data_o  = req_q.is_byte ? wdata_q : req_q.data;

endmodule

// File: tb/tb_cl_dmem_ctrl.sv
// Directed bench for cl_dmem_ctrl with a scripted memory
// responder and hand-computed expected values.
module tb_cl_dmem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_v_i;
    logic        req_ready_o;
    logic [31:0] req_addr_i;
    logic [31:0] req_data_i;
    logic        req_store_i;
    logic        req_byte_i;
    logic        resp_v_o;
    logic [31:0] resp_data_o;
    logic        busy_o;
    logic        mem_v_o;
    logic        mem_ready_i;
    logic        mem_w_o;
    logic [9:0]  mem_addr_o;
    logic [31:0] mem_data_o;
    logic        mem_rv_i;
    logic [31:0] mem_rdata_i;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    cl_dmem_ctrl #(.ADDR_W(10), .DATA_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_v_i     (req_v_i),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr_i),
        .req_data_i  (req_data_i),
        .req_store_i (req_store_i),
        .req_byte_i  (req_byte_i),
        .resp_v_o    (resp_v_o),
        .resp_data_o (resp_data_o),
        .busy_o      (busy_o),
        .mem_v_o     (mem_v_o),
        .mem_ready_i (mem_ready_i),
        .mem_w_o     (mem_w_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .mem_rv_i    (mem_rv_i),
        .mem_rdata_i (mem_rdata_i)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One request driven through a scripted memory. Cycle 1 is the
    // cycle after the accept edge; lat is the cycle resp_v_o is seen.
    task automatic op(input logic st, input logic by,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] rword,
                      input int rdy_wait, input int rv_wait,
                      output int lat, output logic [31:0] rdata,
                      output int nrd, output int nwr, output int nresp,
                      output logic [31:0] wword,
                      output logic [9:0] waddr);
        int cyc, wcnt, rd_acc;
        logic pv, pxfer, pw;
        logic [9:0] pa;
        logic [31:0] pd;
        lat = -1; rdata = '0; nrd = 0; nwr = 0; nresp = 0;
        wword = '0; waddr = '0;
        wcnt = 0; rd_acc = -100;
        pv = 1'b0; pxfer = 1'b0; pw = 1'b0; pa = '0; pd = '0;
        chk("ready_at_issue", {31'b0, req_ready_o}, 32'd1);
        req_v_i = 1'b1; req_addr_i = a; req_data_i = d;
        req_store_i = st; req_byte_i = by;
        step();
        req_v_i = 1'b0;
        chk("busy_after_accept", {31'b0, busy_o}, 32'd1);
        cyc = 1;
        while (cyc < 60) begin
            mem_rv_i = (cyc - rd_acc == rv_wait);
            mem_rdata_i = mem_rv_i ? rword : 32'h0BAD0BAD;
            mem_ready_i = 1'b0;
            if (mem_v_o) begin
                if (pv && !pxfer)
                    chk("mem_hold", {mem_w_o, mem_addr_o, mem_data_o[20:0]},
                        {pw, pa, pd[20:0]});
                if (pv && !pxfer && pw)
                    chk("mem_hold_data", mem_data_o, pd);
                mem_ready_i = (wcnt >= rdy_wait);
                if (mem_ready_i) begin
                    if (mem_w_o) begin
                        nwr++; wword = mem_data_o; waddr = mem_addr_o;
                    end else begin
                        nrd++; rd_acc = cyc;
                    end
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end
            pv = mem_v_o; pxfer = mem_ready_i;
            pw = mem_w_o; pa = mem_addr_o; pd = mem_data_o;
            if (resp_v_o) begin
                nresp++;
                if (lat < 0) begin
                    lat = cyc; rdata = resp_data_o;
                end
            end
            if (lat >= 0 && cyc == lat + 1) break;
            step();
            cyc++;
        end
        mem_rv_i = 1'b0;
        mem_ready_i = 1'b0;
        if (lat < 0) chk("op_timeout", 32'd0, 32'd1);
    endtask

    int lat, nrd, nwr, nresp;
    logic [31:0] rd, ww;
    logic [9:0] wa;
    logic [31:0] lbu_exp [4];
    int acc_cnt, acc2, resp_cnt, resp1, resp2;

    initial begin
        reset = 1'b1; req_v_i = 1'b0; req_addr_i = '0; req_data_i = '0;
        req_store_i = 1'b0; req_byte_i = 1'b0; mem_ready_i = 1'b0;
        mem_rv_i = 1'b0; mem_rdata_i = '0;
        step(); step();
        reset = 1'b0;
        chk("rst_ready", {31'b0, req_ready_o}, 32'd1);
        chk("rst_outs", {28'b0, busy_o, mem_v_o, resp_v_o, mem_w_o}, 32'd0);
        chk("rst_resp_data", resp_data_o, 32'd0);
        chk("rst_mem_addr", {22'b0, mem_addr_o}, 32'd0);
        chk("rst_mem_data", mem_data_o, 32'd0);

        op(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 1,
           lat, rd, nrd, nwr, nresp, ww, wa);
        chk("sw_lat", lat, 2);
        chk("sw_nrd", nrd, 0);
        chk("sw_nwr", nwr, 1);
        chk("sw_waddr", {22'b0, wa}, 32'd4);
        chk("sw_wdata", ww, 32'hDEADBEEF);
        chk("sw_resp", rd, 32'd0);
        chk("sw_npulse", nresp, 1);

        op(1'b0, 1'b0, 32'h13, 32'h0, 32'hDEADBEEF, 0, 1,
           lat, rd, nrd, nwr, nresp, ww, wa);
        chk("lw_lat", lat, 3);
        chk("lw_data", rd, 32'hDEADBEEF);
        chk("lw_nrd", nrd, 1);
        chk("lw_nwr", nwr, 0);

        lbu_exp = '{32'h44, 32'h33, 32'h22, 32'h11};
        for (int i = 0; i < 4; i++) begin
            op(1'b0, 1'b1, 32'h20 + i, 32'h0, 32'h11223344, 0, 1,
               lat, rd, nrd, nwr, nresp, ww, wa);
            chk($sformatf("lbu%0d", i), rd, lbu_exp[i]);
            chk($sformatf("lbu%0d_lat", i), lat, 3);
        end

        op(1'b1, 1'b1, 32'h22, 32'h123456AA, 32'h11223344, 0, 1,
           lat, rd, nrd, nwr, nresp, ww, wa);
        chk("sb_lat", lat, 4);
        chk("sb_nrd", nrd, 1);
        chk("sb_nwr", nwr, 1);
        chk("sb_waddr", {22'b0, wa}, 32'd8);
        chk("sb_wdata", ww, 32'h11AA3344);
        chk("sb_resp", rd, 32'd0);

        op(1'b0, 1'b0, 32'h44, 32'h0, 32'hCAFEF00D, 3, 5,
           lat, rd, nrd, nwr, nresp, ww, wa);
        chk("bp_lw_lat", lat, 10);
        chk("bp_lw_data", rd, 32'hCAFEF00D);
        chk("bp_lw_nrd", nrd, 1);
        chk("bp_lw_npulse", nresp, 1);

        op(1'b1, 1'b1, 32'h07, 32'h0000005B, 32'h01020304, 2, 2,
           lat, rd, nrd, nwr, nresp, ww, wa);
        chk("bp_sb_lat", lat, 9);
        chk("bp_sb_waddr", {22'b0, wa}, 32'd1);
        chk("bp_sb_wdata", ww, 32'h5B020304);
        chk("bp_sb_nrd", nrd, 1);

        // reset while waiting for read data, then a stale return
        req_v_i = 1'b1; req_addr_i = 32'h30; req_store_i = 1'b0;
        req_byte_i = 1'b0;
        step();
        req_v_i = 1'b0; mem_ready_i = 1'b1;
        chk("rr_rdreq", {30'b0, mem_v_o, mem_w_o}, 32'd2);
        step();
        mem_ready_i = 1'b0;
        chk("rr_wait", {30'b0, busy_o, mem_v_o}, 32'd2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rr_idle", {29'b0, req_ready_o, busy_o, mem_v_o}, 32'd4);
        mem_rv_i = 1'b1; mem_rdata_i = 32'hBADBAD00;
        step();
        mem_rv_i = 1'b0;
        chk("rr_no_resp", {31'b0, resp_v_o}, 32'd0);
        chk("rr_stay_idle", {30'b0, req_ready_o, busy_o}, 32'd2);
        step();
        chk("rr_no_resp2", {31'b0, resp_v_o}, 32'd0);
        op(1'b0, 1'b0, 32'h30, 32'h0, 32'h0000ABCD, 0, 1,
           lat, rd, nrd, nwr, nresp, ww, wa);
        chk("rr_lw_lat", lat, 3);
        chk("rr_lw_data", rd, 32'h0000ABCD);

        // request held high across a whole load
        acc_cnt = 0; acc2 = -1; resp_cnt = 0; resp1 = -1; resp2 = -1;
        req_v_i = 1'b1; req_addr_i = 32'h40; req_store_i = 1'b0;
        req_byte_i = 1'b0; mem_ready_i = 1'b1;
        for (int c = 0; c < 8; c++) begin
            mem_rv_i = (mem_v_o === 1'b0) && busy_o && !resp_v_o;
            mem_rdata_i = 32'h600D0000 + c;
            if (req_ready_o && req_v_i) begin
                acc_cnt++;
                if (c > 0 && acc2 < 0) acc2 = c;
            end
            if (resp_v_o) begin
                resp_cnt++;
                if (resp1 < 0) resp1 = c;
                else resp2 = c;
                chk($sformatf("hold_resp_ready%0d", c),
                    {31'b0, req_ready_o}, 32'd0);
            end
            step();
        end
        req_v_i = 1'b0; mem_ready_i = 1'b0; mem_rv_i = 1'b0;
        chk("hold_acc_cnt", acc_cnt, 2);
        chk("hold_acc2", acc2, 4);
        chk("hold_resp_cnt", resp_cnt, 2);
        chk("hold_resp1", resp1, 3);
        chk("hold_resp2", resp2, 7);
        step();
        chk("hold_end_idle", {30'b0, req_ready_o, busy_o}, 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cl_dmem_ctrl.md
Name: cl_dmem_ctrl

Overview:
- Responder for the memory-stage requests that the decode controller flags (load/store, byte/word).
- Takes one pipeline request at a time and drives a word-wide data memory with a valid/ready request channel and a variable-latency read-return channel.
- Performs zero-extended byte loads and read-modify-write byte stores, because the memory has no byte enables.
- Returns a one-cycle response to the pipeline, which stalls on busy_o.

Parameters:
- ADDR_W, 10: word-address width of the data memory. Byte address bits [ADDR_W+1:2] select the word.
- DATA_W, 32: word width. Fixed at 32; any other value is a compile-time error.

Ports:
- clk, input, 1: sole clock. All state updates on the rising edge.
- reset, input, 1: synchronous, active-high.
- req_v_i, input, 1: pipeline request valid.
- req_ready_o, output, 1: controller can accept a request. A request transfers when req_v_i & req_ready_o.
- req_addr_i, input, 32: byte address.
- req_data_i, input, 32: store data. For byte stores only bits [7:0] are used.
- req_store_i, input, 1: 1 = store, 0 = load.
- req_byte_i, input, 1: 1 = byte op (LBU/SB), 0 = word op (LW/SW).
- resp_v_o, output, 1: one-cycle completion pulse, for loads and stores.
- resp_data_o, output, 32: load result, zero-extended for byte loads. 0 for stores.
- busy_o, output, 1: request in flight (state != IDLE).
- mem_v_o, output, 1: memory request valid.
- mem_ready_i, input, 1: memory accepts the request. Transfer when mem_v_o & mem_ready_i.
- mem_w_o, output, 1: 1 = write, 0 = read.
- mem_addr_o, output, ADDR_W: word address.
- mem_data_o, output, 32: write data.
- mem_rv_i, input, 1: read data valid. Arrives at least 1 cycle after the read is accepted.
- mem_rdata_i, input, 32: read data.

Behaviour:
- Reset: at the next edge, state = IDLE. All outputs are 0 except req_ready_o = 1. The latched request registers are cleared.
- Reset mid-operation:
  - Any state returns to IDLE and mem_v_o drops at that edge.
  - An outstanding read return after reset is ignored, because mem_rv_i is only honoured in RD_WAIT.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, RESP.
- IDLE:
  - req_ready_o = 1.
  - On transfer, latch addr, data, store and byte.
  - Next state is WR_REQ for a word store. It is RD_REQ for a load or a byte store.
- RD_REQ:
  - mem_v_o = 1, mem_w_o = 0, mem_addr_o = addr[ADDR_W+1:2].
  - Hold until mem_ready_i, then go to RD_WAIT.
- RD_WAIT:
  - mem_v_o = 0. Wait for mem_rv_i.
  - On mem_rv_i with a load:
    - Word load: latch rdata.
    - Byte load: latch {24'b0, rdata[8*addr[1:0] +: 8]}.
    - Go to RESP.
  - On mem_rv_i with a byte store: merge store byte [7:0] into lane addr[1:0] of rdata, latch as the write word, go to WR_REQ.
- WR_REQ:
  - mem_v_o = 1, mem_w_o = 1, same mem_addr_o.
  - mem_data_o = req_data for a word store, merged word for a byte store.
  - Hold until mem_ready_i, then go to RESP.
- RESP: resp_v_o = 1 for exactly one cycle, with resp_data_o valid. Always go to IDLE. req_ready_o = 0 in this state.
- Byte lanes are little-endian: lane 0 = bits [7:0], lane 3 = bits [31:24].
- Word ops ignore addr[1:0]; there is no misalignment trap.
- While mem_v_o = 1 and mem_ready_i = 0, mem_addr_o, mem_w_o and mem_data_o stay stable.
- resp_data_o holds its last value outside RESP and is only meaningful while resp_v_o = 1.
- Minimum latency (accept edge = cycle 0, memory ready immediately, read data at 1 cycle):
  - Word store: resp_v_o in cycle 2.
  - Load: resp_v_o in cycle 3.
  - Byte store: resp_v_o in cycle 4.
- A new request can be accepted in the cycle after RESP, so the back-to-back issue interval equals the latency plus 1.
- mem_rv_i in any state other than RD_WAIT is ignored.

Decomposition:
- definitions.sv:
  - typedef enum logic [2:0] dmem_state_e {IDLE, RD_REQ, RD_WAIT, WR_REQ, RESP}.
  - typedef struct packed dmem_req_s {addr, data, store, byte}.
- Sub-module cl_byte_lane (combinational), with inputs word, lane, byte. Outputs:
  - extract_o: zero-extended byte at that lane.
  - merge_o: word with the new byte substituted at that lane.

Test Plan:
- Word store then load:
  - Stimulus: SW addr 0x10 data 0xDEADBEEF, mem ready immediately; then LW 0x10 with mem_rdata = 0xDEADBEEF after 1 cycle.
  - Required: mem write to word 4 with data 0xDEADBEEF; resp_v_o in cycle 2; load resp_data_o = 0xDEADBEEF in cycle 3.
- LBU extraction: word 0x11223344 at 0x20, LBU at 0x20/0x21/0x22/0x23 -> 0x44, 0x33, 0x22, 0x11 respectively.
- SB read-modify-write: word 0x11223344, SB 0xAA at 0x22 -> read then write of 0x11AA3344 to word 8; resp_v_o in cycle 4 with resp_data_o = 0.
- Backpressure and variable latency: mem_ready_i low for 3 cycles, mem_rv_i after 5 cycles -> mem_v_o and fields held stable throughout; exactly one read issued; one resp_v_o pulse.
- Reset during RD_WAIT, then stale mem_rv_i -> IDLE next cycle, no resp_v_o, req_ready_o = 1; a following LW completes normally.
- Request held during busy: req_v_i held across the whole of an LW -> second request accepted only in the cycle after RESP; no request is dropped or accepted twice.
